// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter family.
//   arb_state_t  : arbiter FSM state (IDLE, GRANT)
//   clog2_min1() : ceil(log2(value)) clamped to at least 1, for sizing
//                  index/counter fields that must never collapse to 0 bits.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin picker. Returns the first asserted request
// found searching upward from last+1, wrapping modulo N.
// Ports:
//   req    in  N  request vector
//   last   in  W  index of the previous winner (search starts just above it)
//   winner out W  selected index (0 when no request is asserted)
//   any    out 1  at least one request asserted
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] winner,
    output logic         any
);

    // cand[gi] is the index visited at search step gi, i.e. (last+1+gi) mod N.
    // last < N, so the sum is below 2N and a single conditional subtract
    // performs the modulo.
    logic [W-1:0] cand [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [W:0] sum;
            assign sum       = {1'b0, last} + (W+1)'(gi + 1);
            assign cand[gi]  = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
        end
    endgenerate

    assign any = |req;

    // Walk the search order from the far end so the earliest step wins.
    always_comb begin
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                winner = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among NUM_REQ
// valid/ready requesters, granting bursts of up to BURST_LEN beats.
// Build option: define FIFO_WR_ARB_URGENT_EN to make requester 0 urgent
// (wins every arbitration it takes part in, without moving the
// round-robin pointer, and never pre-empts a running burst).
// Ports:
//   clk            in   1                   clock, rising edge
//   rst            in   1                   synchronous active-high reset
//   req_valid      in   NUM_REQ             per-requester beat valid
//   req_data       in   NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      out  NUM_REQ             per-requester accept (one-hot or zero)
//   fifo_we        out  1                   FIFO write enable
//   fifo_data_in   out  DATA_WIDTH          FIFO write data
//   fifo_full      in   1                   FIFO full
//   fifo_occupants in   ADDR_WIDTH+1        FIFO occupancy (observability only)
//   grant_id       out  clog2(NUM_REQ)      granted requester
//   busy           out  1                   high while a grant is active
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              fifo_we,
    output logic [DATA_WIDTH-1:0]             fifo_data_in,
    input  logic                              fifo_full,
    input  logic [ADDR_WIDTH:0]               fifo_occupants,
    output logic [clog2_min1(NUM_REQ)-1:0]    grant_id,
    output logic                              busy
);

    localparam int GW = clog2_min1(NUM_REQ);
    localparam int CW = clog2_min1(BURST_LEN) + 1;

    arb_state_t      state_reg, state_next;
    logic [GW-1:0]   grant_reg, grant_next;
    logic [GW-1:0]   last_reg, last_next;
    logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;

    logic [GW-1:0]   rr_winner;
    logic            rr_any;
    logic            urgent_win;
    logic            grant_valid;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    // Occupancy is exported for debug visibility only; it does not steer
    // arbitration.
    logic unused_occ;
    assign unused_occ = ^fifo_occupants;

    rr_picker #(
        .N (NUM_REQ),
        .W (GW)
    ) u_picker (
        .req    (req_valid),
        .last   (last_reg),
        .winner (rr_winner),
        .any    (rr_any)
    );

`ifdef FIFO_WR_ARB_URGENT_EN
    assign urgent_win = req_valid[0];
`else
    assign urgent_win = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = (state_reg == GRANT) && (grant_reg == GW'(gi)) && !fifo_full;
        end
    endgenerate

    assign grant_valid  = req_valid[grant_reg];
    assign fifo_we      = |(req_ready & req_valid);
    assign fifo_data_in = data_arr[grant_reg];
    assign grant_id     = grant_reg;
    assign busy         = (state_reg == GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            last_reg     <= GW'(NUM_REQ - 1);
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            last_reg     <= last_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        last_next     = last_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (rr_any) begin
                    state_next    = GRANT;
                    beat_cnt_next = '0;
                    if (urgent_win) begin
                        // Urgent wins leave the pointer alone so the
                        // rotation among the others is unaffected.
                        grant_next = '0;
                    end else begin
                        grant_next = rr_winner;
                        last_next  = rr_winner;
                    end
                end
            end
            GRANT: begin
                if (!grant_valid) begin
                    state_next = IDLE;
                end else if (!fifo_full) begin
                    // Counter stops at BURST_LEN because the grant ends on
                    // the same beat, so it cannot wrap.
                    beat_cnt_next = beat_cnt_reg + CW'(1);
                    if (beat_cnt_reg == CW'(BURST_LEN - 1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int BL = 4;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_we;
    logic [DW-1:0]     fifo_data_in;
    logic              fifo_full;
    logic [AW:0]       fifo_occupants;
    logic [GW-1:0]     grant_id;
    logic              busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BURST_LEN  (BL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .fifo_we        (fifo_we),
        .fifo_data_in   (fifo_data_in),
        .fifo_full      (fifo_full),
        .fifo_occupants (fifo_occupants),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    typedef struct {
        logic         rst;
        logic [N-1:0] valid;
        logic         full;
        logic         busy;
        logic [GW-1:0] grant;
        logic [N-1:0] ready;
        logic         we;
        logic [DW-1:0] data;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fixed_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'(8'hC0 + i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        fifo_occupants = '0;
        set_fixed_data();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Raise the given valid mask until one beat is written, then drop all
    // valids and let the arbiter return to IDLE. Reports the granted index.
    task automatic grant_once(input logic [N-1:0] mask, output int g);
        bit got;
        got = 1'b0;
        g = -1;
        req_valid = mask;
        for (int c = 0; c < 8 && !got; c++) begin
            #4;
            if (fifo_we) begin
                g = grant_id;
                got = 1'b1;
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        if (!got) chk("grant_once_timeout", 0, 1);
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int k;
        int wr_cyc [$];
        logic [DW-1:0] wr_dat [$];
        int wr_gnt [$];

        rst = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        fifo_occupants = '0;
        req_data = '0;

        //            rst valid    full busy grant ready    we  data
        tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 4'b1010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hC1};
        tbl[3]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 4'b1000, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hC3};
        tbl[7]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hC2};
        tbl[10] = '{1'b1, 4'b1111, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hC2};
        tbl[11] = '{1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hC0};

        // ---------------- table-driven vectors ----------------
        do_reset();
        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst;
            req_valid = tbl[i].valid;
            fifo_full = tbl[i].full;
            #4;
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("vec%0d_grant", i), grant_id, tbl[i].grant);
            chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].ready);
            chk($sformatf("vec%0d_we", i), fifo_we, tbl[i].we);
            if (tbl[i].we) chk($sformatf("vec%0d_data", i), fifo_data_in, tbl[i].data);
            $display("vec %0d rst=%b valid=%b full=%b -> busy=%b grant=%0d ready=%b we=%b data=%h",
                     i, rst, req_valid, fifo_full, busy, grant_id, req_ready, fifo_we, fifo_data_in);
            tick();
        end
        rst = 1'b0;

        // ---------------- requester 2, six beats ----------------
        do_reset();
        k = 0;
        wr_cyc.delete();
        wr_dat.delete();
        for (int c = 0; c < 12; c++) begin
            req_valid = (k < 6) ? 4'b0100 : 4'b0000;
            req_data[2*DW +: DW] = 8'(8'hA0 + k);
            #4;
            if (fifo_we) begin
                wr_cyc.push_back(c);
                wr_dat.push_back(fifo_data_in);
                $display("burst6 cyc %0d write data=%h", c, fifo_data_in);
            end
            g = int'(req_valid[2] & req_ready[2]);
            tick();
            k = k + g;
        end
        chk("burst6_count", wr_cyc.size(), 6);
        begin
            int exp_c [6] = '{1, 2, 3, 4, 6, 7};
            for (int j = 0; j < 6; j++) begin
                if (j < wr_cyc.size()) begin
                    chk($sformatf("burst6_cyc%0d", j), wr_cyc[j], exp_c[j]);
                    chk($sformatf("burst6_dat%0d", j), wr_dat[j], 8'hA0 + j);
                end
            end
        end

        // ---------------- all four continuously valid ----------------
        do_reset();
        wr_gnt.delete();
        req_valid = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            #4;
            if (fifo_we) begin
                wr_gnt.push_back(grant_id);
                $display("contend cyc %0d write grant=%0d data=%h", c, grant_id, fifo_data_in);
            end
            tick();
        end
        req_valid = '0;
        chk("contend_count", wr_gnt.size(), 20);
        for (int j = 0; j < 20; j++) begin
            if (j < wr_gnt.size()) begin
`ifdef FIFO_WR_ARB_URGENT_EN
                chk($sformatf("contend_grant%0d", j), wr_gnt[j], 0);
`else
                chk($sformatf("contend_grant%0d", j), wr_gnt[j], (j / 4) % 4);
`endif
            end
        end

        // ---------------- full stall mid-burst ----------------
        do_reset();
        k = 0;
        wr_cyc.delete();
        wr_dat.delete();
        for (int c = 0; c < 12; c++) begin
            req_valid = (k < 4) ? 4'b0001 : 4'b0000;
            req_data[0 +: DW] = 8'(8'h50 + k);
            fifo_full = (c >= 3 && c <= 5);
            #4;
            if (c >= 3 && c <= 5) begin
                chk($sformatf("stall_c%0d_ready", c), req_ready, 0);
                chk($sformatf("stall_c%0d_we", c), fifo_we, 0);
                chk($sformatf("stall_c%0d_busy", c), busy, 1);
            end
            if (fifo_we) begin
                wr_cyc.push_back(c);
                wr_dat.push_back(fifo_data_in);
                $display("stall cyc %0d write data=%h", c, fifo_data_in);
            end
            g = int'(req_valid[0] & req_ready[0]);
            tick();
            k = k + g;
        end
        fifo_full = 1'b0;
        chk("stall_count", wr_cyc.size(), 4);
        begin
            int exp_c [4] = '{1, 2, 6, 7};
            for (int j = 0; j < 4; j++) begin
                if (j < wr_cyc.size()) begin
                    chk($sformatf("stall_cyc%0d", j), wr_cyc[j], exp_c[j]);
                    chk($sformatf("stall_dat%0d", j), wr_dat[j], 8'h50 + j);
                end
            end
        end

`ifdef FIFO_WR_ARB_URGENT_EN
        // ---------------- urgent requester 0 ----------------
        do_reset();
        grant_once(4'b0010, g);
        chk("urgent_setup_grant", g, 1);
        $display("urgent setup grant=%0d", g);
        grant_once(4'b0101, g);
        chk("urgent_win_grant", g, 0);
        $display("urgent win grant=%0d", g);
        grant_once(4'b1110, g);
        chk("urgent_rr_resume", g, 2);
        $display("urgent rr resume grant=%0d", g);
`endif

        // ---------------- randomized vs. reference model ----------------
        do_reset();
        begin
            int mb, mo, ml, mc, occ;
            int seq [N];
            logic [N-1:0] v;
            logic [N-1:0] acc;
            logic [N-1:0] exp_ready;
            logic exp_we;
            mb = 0; mo = 0; ml = N - 1; mc = 0; occ = 0;
            v = '0;
            for (int i = 0; i < N; i++) seq[i] = 0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                rst = ($urandom_range(0, 99) == 0);
                for (int i = 0; i < N; i++) begin
                    if (!v[i] && $urandom_range(0, 99) < 40) v[i] = 1'b1;
                    req_data[i*DW +: DW] = 8'((i << 6) | (seq[i] & 63));
                end
                req_valid = v;
                fifo_full = (occ >= 16);
                fifo_occupants = 5'(occ);
                exp_ready = (mb != 0 && !fifo_full) ? 4'(1 << mo) : 4'b0000;
                exp_we = |(exp_ready & req_valid);
                #4;
                chk("rnd_busy", busy, mb);
                chk("rnd_grant", grant_id, mo);
                chk("rnd_ready", req_ready, exp_ready);
                chk("rnd_we", fifo_we, exp_we);
                if (exp_we) begin
                    chk("rnd_data", fifo_data_in, req_data[mo*DW +: DW]);
                    $display("rand cyc %0d write req=%0d data=%h", cyc, mo, fifo_data_in);
                end
                acc = req_valid & req_ready;
                if (rst) begin
                    mb = 0; mo = 0; ml = N - 1; mc = 0;
                end else if (mb == 0) begin
                    if (req_valid != 0) begin
`ifdef FIFO_WR_ARB_URGENT_EN
                        if (req_valid[0]) mo = 0;
                        else begin
                            mo = rr_pick(req_valid, ml);
                            ml = mo;
                        end
`else
                        mo = rr_pick(req_valid, ml);
                        ml = mo;
`endif
                        mb = 1;
                        mc = 0;
                    end
                end else if (!req_valid[mo]) begin
                    mb = 0;
                end else if (!fifo_full) begin
                    mc++;
                    if (mc == BL) mb = 0;
                end
                occ = occ + (fifo_we ? 1 : 0);
                if (occ > 0 && $urandom_range(0, 1) == 1) occ--;
                tick();
                for (int i = 0; i < N; i++) begin
                    if (acc[i]) begin
                        seq[i]++;
                        v[i] = ($urandom_range(0, 99) < 70);
                    end
                end
            end
        end
        rst = 1'b0;
        req_valid = '0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `fifo` write port among `NUM_REQ` requesters. Each requester uses a valid/ready handshake. The arbiter grants one requester at a time for bursts of up to `BURST_LEN` beats and drives `we`/`data_in` of the shared FIFO. It stalls on FIFO `full` and never drops or duplicates a beat.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: beat width; must equal the FIFO `DATA_WIDTH`.
- `ADDR_WIDTH`, default 8: FIFO address width; sizes `fifo_occupants`.
- `BURST_LEN`, default 4: maximum beats per grant, ≥1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-requester beat accepted; one-hot or zero.
- `fifo_we`  out  1  FIFO write enable.
- `fifo_data_in`  out  DATA_WIDTH  FIFO write data.
- `fifo_full`  in  1  FIFO `full`.
- `fifo_occupants`  in  ADDR_WIDTH+1  FIFO occupancy; observability only, not used for control.
- `grant_id`  out  clog2(NUM_REQ)  currently granted requester.
- `busy`  out  1  high while in GRANT.

## Operation
- FSM with two states:
  - IDLE: if any `req_valid` is high, pick a winner, register it in `grant_id` and `last_grant`, clear `beat_cnt`, and go to GRANT. Otherwise stay.
  - GRANT: a beat transfers when `req_valid[grant_id] && !fifo_full`. Each transfer increments `beat_cnt`.
  - GRANT → IDLE when a transfer occurs with `beat_cnt == BURST_LEN-1`, or when `req_valid[grant_id]` is low (requester done).
- Winner selection, round-robin: the first valid requester searching upward from `last_grant+1`, modulo `NUM_REQ`.
- Combinational outputs:
  - `req_ready[i]` = GRANT && `grant_id == i` && !`fifo_full`.
  - `fifo_we` = `|(req_ready & req_valid)`.
  - `fifo_data_in` = `req_data` slice of `grant_id` (mux is always driven).
- `busy` = (state == GRANT).
- `fifo_full` high in GRANT: no ready and no write. `beat_cnt` and the grant are held. The grant stays until the requester drops valid or the burst completes.
- The arbiter never writes while `fifo_full` is high, so it cannot overflow the FIFO.
- `beat_cnt` is clog2(BURST_LEN)+1 bits wide and saturates by construction; no wrap.
- The `last_grant` pointer wraps from `NUM_REQ-1` to 0.

## Timing
- Reset values: state IDLE, `grant_id` 0, `last_grant` NUM_REQ-1 (requester 0 wins first), `beat_cnt` 0, `busy` 0, `req_ready` 0, `fifo_we` 0.
- `rst` asserted mid-burst: the FSM returns to IDLE at the next edge. Outputs are 0 during the cycle after the reset edge, and no beat is accepted in that cycle.
- Arbitration takes 1 cycle. `req_valid` rises in cycle N (IDLE) → `req_ready` high in cycle N+1.
- There is a one-cycle IDLE bubble between consecutive grants. Sustained throughput with continuous contention is BURST_LEN/(BURST_LEN+1).
- Beat acceptance is same-cycle. The FIFO sees `we` in the cycle `req_valid & req_ready`, and `full` reflects that write one cycle later.
- Requesters must hold `req_valid` and `req_data` stable until `req_ready`.

## Configuration
- Macro `FIFO_WR_ARB_URGENT_EN`.
- Defined: requester 0 is urgent.
  - In IDLE, `req_valid[0]` wins regardless of the round-robin pointer.
  - An urgent win does not update `last_grant`, so fairness among the other requesters is preserved.
  - It does not pre-empt a burst in progress.
- Undefined: pure round-robin for all requesters.

## Structure
- Package `fifo_arb_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT};
  - width helper function `clog2_min1` (returns ≥1).
- Sub-module `rr_picker`: combinational, inputs `req` and `last`, outputs `winner` and `any`. It is reused for other shared-resource arbiters.
- Top level holds the FSM, counters, data mux and macro gating.

## Test plan
- `NUM_REQ`=4, `BURST_LEN`=4; requester 2 presents 6 beats 0xA0..0xA5 → writes at cycles 1–4, IDLE at cycle 5, writes at 6–7; FIFO holds 0xA0..0xA5 in order.
- All four requesters continuously valid → `grant_id` sequence 0,1,2,3,0, each grant exactly 4 `fifo_we` cycles.
- `fifo_full` forced high for 3 cycles after beat 2 of a burst → `req_ready`/`fifo_we` low for those 3 cycles, `beat_cnt` held at 2; beats 3–4 follow, no beat is lost.
- Requester 1 drops valid after 1 beat while requester 3 is waiting → 1 write, IDLE, then `grant_id`=3.
- `rst` pulsed mid-burst with `grant_id`=2 → next cycle `busy`=0, `fifo_we`=0; with all requesters valid, the first grant after reset is 0.
- With `FIFO_WR_ARB_URGENT_EN`, `last_grant`=0, requesters 0 and 2 valid → `grant_id`=0. Then, with only 1 and 2 valid, `grant_id`=1.
